// File: rtl/uart_byte_rx.sv
`timescale 1ns/1ps
// uart_byte_rx: 8N1 UART receiver using 16x oversampling from a phase accumulator.
// Good frames raise a one-cycle byte strobe; a low stop bit raises a one-cycle error strobe.
module uart_byte_rx #(
  parameter int CLK_FREQ = 100_000_000,
  parameter int ACC_W    = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [19:0] speed,
  input  logic        rx,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  output logic        rx_busy,
  output logic        frame_err
);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rxState_t;

  rxState_t         state_q;
  logic             rxMeta_q;
  logic             rxSync_q;
  logic             rxPrev_q;
  logic [19:0]      spd_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] accSum_d;
  logic [ACC_W-1:0] accNext_d;
  logic             tick_d;
  logic [3:0]       tickCnt_q;
  logic [2:0]       bitCnt_q;
  logic [7:0]       shift_q;

  // Two-flop synchronizer plus one delayed copy for falling-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
      rxPrev_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
      rxPrev_q <= rxSync_q;
    end
  end

  // Each clock adds 16*baud; every CLK_FREQ wrap is one oversample tick.
  always_comb begin
    accSum_d  = acc_q + ACC_W'({spd_q, 4'b0000});
    tick_d    = (accSum_d >= ACC_W'(CLK_FREQ));
    accNext_d = accSum_d;
    if (tick_d) begin
      accNext_d = accSum_d - ACC_W'(CLK_FREQ);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      spd_q     <= '0;
      acc_q     <= '0;
      tickCnt_q <= '0;
      bitCnt_q  <= '0;
      shift_q   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      rx_busy   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      if (state_q != IDLE) begin
        acc_q <= accNext_d;
      end
      case (state_q)
        IDLE: begin
          if (rxPrev_q && !rxSync_q) begin
            state_q   <= START;
            tickCnt_q <= '0;
            acc_q     <= '0;
            spd_q     <= speed;
            rx_busy   <= 1'b1;
          end
        end
        START: begin
          if (tick_d) begin
            if (tickCnt_q == 4'd7) begin
              // A line that is high again at mid start bit was only a glitch.
              if (rxSync_q) begin
                state_q <= IDLE;
                rx_busy <= 1'b0;
              end else begin
                state_q   <= DATA;
                tickCnt_q <= '0;
                bitCnt_q  <= '0;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        DATA: begin
          if (tick_d) begin
            if (tickCnt_q == 4'd15) begin
              shift_q[bitCnt_q] <= rxSync_q;
              tickCnt_q         <= '0;
              bitCnt_q          <= bitCnt_q + 3'd1;
              if (bitCnt_q == 3'd7) begin
                state_q <= STOP;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        STOP: begin
          if (tick_d) begin
            if (tickCnt_q == 4'd15) begin
              tickCnt_q <= '0;
              // Leaving at mid stop bit lets a gapless next start edge be seen.
              if (rxSync_q) begin
                rx_data  <= shift_q;
                rx_valid <= 1'b1;
                rx_busy  <= 1'b0;
                state_q  <= IDLE;
              end else begin
                frame_err <= 1'b1;
                state_q   <= BREAK;
              end
            end else begin
              tickCnt_q <= tickCnt_q + 4'd1;
            end
          end
        end
        BREAK: begin
          if (rxSync_q) begin
            state_q <= IDLE;
            rx_busy <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_byte_rx.md
Name: uart_byte_rx

Overview:
Byte-level UART receiver; the receive-side counterpart of uart_byte_tx. It recovers 8N1 frames from the asynchronous `rx` line using 16x oversampling derived from the runtime `speed` input. It delivers each byte with a single-cycle valid strobe and flags framing errors. It sits beside uart_byte_tx inside the UART top and shares its `speed` encoding, which is the baud rate in bits/s.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz. Must be ≥ 16*speed for every speed used.
ACC_W, 32, width of the baud phase accumulator. Must hold CLK_FREQ + 16*2^20.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
speed  input  20  baud rate in bits/s (110 … 921600)
rx  input  1  serial line; idle high; asynchronous to clk
rx_data  output  8  last correctly received byte; held until the next good frame
rx_valid  output  1  one-cycle pulse: rx_data has just been updated
rx_busy  output  1  high from start-edge detection until return to IDLE
frame_err  output  1  one-cycle pulse: stop bit sampled low

Behaviour:
- Reset (asynchronous, active-high; one clock, no other clock domains):
  - rx_data=0x00, rx_valid=0, rx_busy=0, frame_err=0.
  - Synchronizer flops = 1; state=IDLE; all counters and the accumulator = 0.
- rx passes through a 2-flop synchronizer to give rx_s. All decisions use rx_s, which adds 2 cycles of latency.
- Oversample tick generator (phase accumulator):
  - While not IDLE, every clk: acc <= acc + 16*speed.
  - If that sum ≥ CLK_FREQ: acc <= sum − CLK_FREQ and tick=1 for that cycle.
  - acc is cleared on entry to START.
  - speed is latched into spd_q at start detection and is used for the whole frame. A speed change mid-frame has no effect until the next frame.
  - spd_q=0 produces no ticks. Such a frame never completes; only reset recovers. This is a documented restriction, and callers must not set speed=0.
- States: IDLE, START, DATA, STOP, BREAK.
  - IDLE: rx_busy=0. On rx_s falling (previous 1, current 0): go to START, tick_cnt=0, rx_busy=1, latch spd_q.
  - START: count ticks. At tick_cnt=7 (mid start bit):
    - If rx_s=1, it is a false start: go to IDLE, rx_busy=0, no strobe.
    - Otherwise go to DATA with tick_cnt=0, bit_cnt=0.
  - DATA: on every 16th tick (tick_cnt=15), sample rx_s into shift[bit_cnt]. Bits are LSB first. After bit_cnt=7, go to STOP with tick_cnt=0.
  - STOP: at tick_cnt=15:
    - rx_s=1: rx_data<=shift, rx_valid=1 for exactly the next cycle, go to IDLE.
    - rx_s=0: frame_err=1 for exactly the next cycle, rx_data unchanged, go to BREAK.
  - BREAK: rx_busy stays 1. Wait until rx_s=1, then go to IDLE. No start detection happens in BREAK.
- Returning to IDLE at the mid stop bit allows back-to-back frames with zero idle gap. The next start edge is detected within the second half of the stop bit period.
- rx_valid and frame_err are never high in the same cycle. Neither is ever high for more than 1 cycle.
- Latency: rx_valid rises 1 clk after the tick that samples the stop bit. That is about 9.5 bit times plus 3 clk after the line's start edge.
- Reset asserted mid-frame: immediate return to reset values. The partial byte is discarded.

Test Plan:
- CLK_FREQ=100e6, speed=115200, frame 0xA5 with 1 stop bit -> exactly one rx_valid pulse; rx_data=0xA5; frame_err stays 0; rx_busy=1 from about 3 clk after the start edge until the valid cycle.
- Low glitch of 200 clk on an idle line (shorter than 8 ticks ≈ 434 clk) -> no rx_valid, no frame_err; rx_busy drops; rx_data unchanged; a following 0x5A frame is received correctly.
- After a good 0x11 frame, send 0x3C with stop bit 0 held low for 2 bit times -> frame_err pulses once; rx_data stays 0x11; rx_valid=0; rx_busy falls only after the line returns high; a next frame of 0x42 is received as 0x42.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three rx_valid pulses, rx_data sequence 0x00, 0xFF, 0x81, no frame_err.
- speed=9600, frame 0xC3 -> received as 0xC3. Change speed to 115200 during DATA -> the current frame is still decoded at 9600 and a subsequent 115200 frame is decoded correctly.
- reset pulse during bit 4 of frame 0xF0 -> all outputs return to 0 asynchronously; no rx_valid for that frame; the next frame 0x0F is received as 0x0F.
